// File: rtl/uart_top_core_pkg.sv
// ============================================================================
//  Module      : uart_top_core_pkg
//  Description : Shared constants and state encoding for the 8N1 UART core.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_top_core_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = 7;
    localparam int TICK_IDX_W   = 4;

    localparam logic [TICK_IDX_W-1:0] TICK_LAST  = TICK_IDX_W'(OVERSAMPLE - 1);
    localparam logic [TICK_IDX_W-1:0] TICK_START = TICK_IDX_W'(START_SAMPLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_top_core_if.sv
// ============================================================================
//  Module      : uart_top_core_if
//  Description : CPU-side byte bus of the UART core (push/pop, flags, pulses).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_top_core_if #(
    parameter int NB_DATA = 8
);
    logic               i_tx_start;
    logic               i_wr;
    logic [NB_DATA-1:0] i_wdata;
    logic               i_rd;
    logic [NB_DATA-1:0] o_rdata;
    logic               o_tx_done;
    logic               o_tx_empty;
    logic               o_tx_full;
    logic               o_rx_done;
    logic               o_rx_empty;
    logic               o_rx_full;

    modport master (
        output i_tx_start, i_wr, i_wdata, i_rd,
        input  o_rdata, o_tx_done, o_tx_empty, o_tx_full,
        input  o_rx_done, o_rx_empty, o_rx_full
    );

    modport slave (
        input  i_tx_start, i_wr, i_wdata, i_rd,
        output o_rdata, o_tx_done, o_tx_empty, o_tx_full,
        output o_rx_done, o_rx_empty, o_rx_full
    );
endinterface

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous first-word fall-through FIFO; reads 0 when empty.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  wire logic               clk,
    input  wire logic               i_rst,
    input  wire logic               i_push,
    input  wire logic               i_pop,
    input  wire logic [NB_DATA-1:0] i_wdata,
    output logic      [NB_DATA-1:0] o_rdata,
    output logic                    o_empty,
    output logic                    o_full
);
    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem_q [DEPTH];
    logic [NB_ADDR-1:0] wptr_q;
    logic [NB_ADDR-1:0] rptr_q;
    logic [NB_ADDR:0]   count_q;
    logic               w_we;
    logic               w_re;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (NB_ADDR + 1)'(DEPTH));
    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign w_we    = i_push && (!o_full || i_pop);
    assign w_re    = i_pop && !o_empty;
    assign o_rdata = o_empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (w_we) mem_q[wptr_q] <= i_wdata;
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_we) wptr_q <= wptr_q + 1'b1;
            if (w_re) rptr_q <= rptr_q + 1'b1;
            case ({w_we, w_re})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/uart_top_core.sv
// ============================================================================
//  Module      : uart_top_core
//  Description : 8N1 UART with baud-tick generator, 16x oversampling RX and
//                TX/RX FIFOs. Define UART_RX_SYNC_EN to synchronise i_rx.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_top_core
    import uart_top_core_pkg::*;
#(
    parameter int NB_COUNTER   = 9,
    parameter int NB_DATA      = 8,
    parameter int NB_FIFO_ADDR = 4
) (
    input  wire logic                  clk,
    input  wire logic                  i_rst,
    input  wire logic                  i_rx,
    input  wire logic [NB_COUNTER-1:0] i_tick_cmp,
    output logic                       o_tx,
    uart_top_core_if.slave             bus
);
    localparam int NB_BIT = $clog2(NB_DATA);
    localparam logic [NB_BIT-1:0] BIT_LAST = NB_BIT'(NB_DATA - 1);

    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic                  w_tick;
    logic                  w_rx;

    uart_state_e           tx_state_q;
    logic [TICK_IDX_W-1:0] tx_tick_q;
    logic [NB_BIT-1:0]     tx_bit_q;
    logic [NB_DATA-1:0]    tx_sh_q;
    logic                  tx_q, tx_done_q, tx_arm_q;
    logic                  w_tx_pop, w_tx_empty;
    logic [NB_DATA-1:0]    w_tx_rdata;

    uart_state_e           rx_state_q;
    logic [TICK_IDX_W-1:0] rx_tick_q;
    logic [NB_BIT-1:0]     rx_bit_q;
    logic [NB_DATA-1:0]    rx_sh_q;
    logic                  rx_done_q;
    logic                  w_rx_push, w_rx_full;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q;
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) rx_sync_q <= 2'b11;
        else        rx_sync_q <= {rx_sync_q[0], i_rx};
    end
    assign w_rx = rx_sync_q[1];
`else
    assign w_rx = i_rx;
`endif

    assign w_tick = (i_tick_cmp <= NB_COUNTER'(1)) || (cnt_q >= i_tick_cmp - NB_COUNTER'(1));
    assign cnt_d  = w_tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // The next frame is fetched on a tick, either from IDLE or straight out of STOP.
    assign w_tx_pop = w_tick && tx_arm_q && !w_tx_empty &&
                      ((tx_state_q == ST_IDLE) ||
                       (tx_state_q == ST_STOP && tx_tick_q == TICK_LAST));

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            tx_arm_q   <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state_q)
                ST_IDLE: begin
                    if (w_tx_pop) begin
                        tx_state_q <= ST_START;
                        tx_tick_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_sh_q    <= w_tx_rdata;
                        tx_q       <= 1'b0;
                    end
                end
                ST_START: if (w_tick) begin
                    if (tx_tick_q == TICK_LAST) begin
                        tx_state_q <= ST_DATA;
                        tx_tick_q  <= '0;
                        tx_q       <= tx_sh_q[0];
                    end else tx_tick_q <= tx_tick_q + 1'b1;
                end
                ST_DATA: if (w_tick) begin
                    if (tx_tick_q == TICK_LAST) begin
                        tx_tick_q <= '0;
                        if (tx_bit_q == BIT_LAST) begin
                            tx_state_q <= ST_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_q     <= tx_sh_q[1];
                        end
                    end else tx_tick_q <= tx_tick_q + 1'b1;
                end
                ST_STOP: if (w_tick) begin
                    if (tx_tick_q == TICK_LAST) begin
                        tx_done_q <= 1'b1;
                        tx_tick_q <= '0;
                        if (w_tx_pop) begin
                            tx_state_q <= ST_START;
                            tx_bit_q   <= '0;
                            tx_sh_q    <= w_tx_rdata;
                            tx_q       <= 1'b0;
                        end else begin
                            tx_state_q <= ST_IDLE;
                            if (w_tx_empty) tx_arm_q <= 1'b0;
                        end
                    end else tx_tick_q <= tx_tick_q + 1'b1;
                end
                default: tx_state_q <= ST_IDLE;
            endcase
            if (bus.i_tx_start) tx_arm_q <= 1'b1;
        end
    end

    assign w_rx_push = w_tick && (rx_state_q == ST_STOP) && (rx_tick_q == TICK_LAST) &&
                       w_rx && !w_rx_full;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state_q)
                ST_IDLE: begin
                    if (!w_rx) begin
                        rx_state_q <= ST_START;
                        rx_tick_q  <= '0;
                    end
                end
                ST_START: if (w_tick) begin
                    if (rx_tick_q == TICK_START) begin
                        rx_state_q <= w_rx ? ST_IDLE : ST_DATA;
                        rx_tick_q  <= '0;
                        rx_bit_q   <= '0;
                    end else rx_tick_q <= rx_tick_q + 1'b1;
                end
                ST_DATA: if (w_tick) begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_tick_q <= '0;
                        rx_sh_q   <= {w_rx, rx_sh_q[NB_DATA-1:1]};
                        if (rx_bit_q == BIT_LAST) rx_state_q <= ST_STOP;
                        else                      rx_bit_q   <= rx_bit_q + 1'b1;
                    end else rx_tick_q <= rx_tick_q + 1'b1;
                end
                ST_STOP: if (w_tick) begin
                    if (rx_tick_q == TICK_LAST) begin
                        rx_state_q <= ST_IDLE;
                        rx_tick_q  <= '0;
                        rx_done_q  <= w_rx_push;
                    end else rx_tick_q <= rx_tick_q + 1'b1;
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    uart_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_FIFO_ADDR)) u_tx_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_push  (bus.i_tx_start | bus.i_wr),
        .i_pop   (w_tx_pop),
        .i_wdata (bus.i_wdata),
        .o_rdata (w_tx_rdata),
        .o_empty (w_tx_empty),
        .o_full  (bus.o_tx_full)
    );

    uart_fifo #(.NB_DATA(NB_DATA), .NB_ADDR(NB_FIFO_ADDR)) u_rx_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_push  (w_rx_push),
        .i_pop   (bus.i_rd),
        .i_wdata (rx_sh_q),
        .o_rdata (bus.o_rdata),
        .o_empty (bus.o_rx_empty),
        .o_full  (w_rx_full)
    );

    assign o_tx           = tx_q;
    assign bus.o_tx_done  = tx_done_q;
    assign bus.o_tx_empty = w_tx_empty;
    assign bus.o_rx_done  = rx_done_q;
    assign bus.o_rx_full  = w_rx_full;
endmodule

`default_nettype wire

// File: tb/tb_uart_top_core.sv
// ============================================================================
//  Module      : tb_uart_top_core
//  Description : Directed self-checking bench for uart_top_core.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_top_core;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [8:0] i_tick_cmp;
    logic       o_tx;
    logic       loop_en;
    logic       rx_man;
    logic       w_rx;
    int         period;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_tx_done = 0;
    int         n_rx_done = 0;

    uart_top_core_if #(.NB_DATA(8)) bus ();

    assign w_rx = loop_en ? o_tx : rx_man;

    uart_top_core dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_rx       (w_rx),
        .i_tick_cmp (i_tick_cmp),
        .o_tx       (o_tx),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_tx_done) n_tx_done <= n_tx_done + 1;
        if (bus.o_rx_done) n_rx_done <= n_rx_done + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic start, input logic [7:0] d);
        @(negedge clk);
        bus.i_tx_start = start;
        bus.i_wr       = ~start;
        bus.i_wdata    = d;
        @(negedge clk);
        bus.i_tx_start = 1'b0;
        bus.i_wr       = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.i_rd = 1'b1;
        @(negedge clk);
        bus.i_rd = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag, input int target, input int budget);
        int c = 0;
        while (n_tx_done < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk_eq(tag, 32'(n_tx_done >= target), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx_man = 1'b0;
        repeat (16 * period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_man = b[i];
            repeat (16 * period) @(negedge clk);
        end
        rx_man = stop_ok;
        repeat ((stop_ok ? 16 : 12) * period) @(negedge clk);
        rx_man = 1'b1;
        repeat (8 * period) @(negedge clk);
    endtask

    initial begin
        int         c;
        int         lowcnt;
        int         base_tx;
        int         base_rx;
        logic [7:0] bits;
        logic       seen_low;

        i_rst          = 1'b0;
        i_tick_cmp     = 9'h146;
        period         = 326;
        loop_en        = 1'b1;
        rx_man         = 1'b1;
        bus.i_tx_start = 1'b0;
        bus.i_wr       = 1'b0;
        bus.i_wdata    = 8'h00;
        bus.i_rd       = 1'b0;

        repeat (3) @(negedge clk);
        chk_eq("rst_tx", o_tx, 1);
        chk_eq("rst_tx_empty", bus.o_tx_empty, 1);
        chk_eq("rst_tx_full", bus.o_tx_full, 0);
        chk_eq("rst_rx_empty", bus.o_rx_empty, 1);
        chk_eq("rst_rx_full", bus.o_rx_full, 0);
        chk_eq("rst_rdata", bus.o_rdata, 0);
        chk_eq("rst_done", {bus.o_tx_done, bus.o_rx_done}, 0);
        i_rst = 1'b1;

        // Single loopback frame 0x01 at the nominal 19200-baud setting
        base_tx = n_tx_done;
        base_rx = n_rx_done;
        push(1'b1, 8'h01);
        c = 0;
        while (o_tx !== 1'b0 && c < period + 8) begin
            @(negedge clk);
            c++;
        end
        chk_eq("tx_fall", o_tx, 0);
        lowcnt = 0;
        while (o_tx === 1'b0 && lowcnt < 20000) begin
            @(negedge clk);
            lowcnt++;
        end
        chk_eq("start_len", lowcnt, 16 * 326);
        for (int i = 0; i < 8; i++) begin
            repeat (i == 0 ? 8 * period : 16 * period) @(negedge clk);
            bits[i] = o_tx;
        end
        chk_eq("tx_bits", bits, 8'h01);
        wait_tx_done("tx_done_wait1", base_tx + 1, 40 * period);
        repeat (20) @(negedge clk);
        chk_eq("tx_done_cnt1", n_tx_done - base_tx, 1);
        chk_eq("rx_done_cnt1", n_rx_done - base_rx, 1);
        chk_eq("rdata1", bus.o_rdata, 8'h01);
        chk_eq("rx_empty1", bus.o_rx_empty, 0);
        pop();
        chk_eq("rx_empty_pop", bus.o_rx_empty, 1);
        chk_eq("rdata_empty", bus.o_rdata, 0);

        // Faster baud for the remaining scenarios
        @(negedge clk);
        i_tick_cmp = 9'd3;
        period     = 3;

        // Unarmed writes stay queued; a start sends everything back-to-back
        base_tx = n_tx_done;
        base_rx = n_rx_done;
        push(1'b0, 8'hA5);
        push(1'b0, 8'h5A);
        seen_low = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx !== 1'b1) seen_low = 1'b1;
        end
        chk_eq("unarmed_idle", seen_low, 0);
        chk_eq("unarmed_not_empty", bus.o_tx_empty, 0);
        push(1'b1, 8'h3C);
        wait_tx_done("tx_done_wait3", base_tx + 3, 3 * 160 * 3 + 200);
        repeat (20) @(negedge clk);
        chk_eq("tx_done_cnt3", n_tx_done - base_tx, 3);
        chk_eq("rx_done_cnt3", n_rx_done - base_rx, 3);
        chk_eq("b2b_byte0", bus.o_rdata, 8'hA5);
        pop();
        chk_eq("b2b_byte1", bus.o_rdata, 8'h5A);
        pop();
        chk_eq("b2b_byte2", bus.o_rdata, 8'h3C);
        pop();
        chk_eq("b2b_rx_empty", bus.o_rx_empty, 1);

        // Seventeen writes into a 16-deep FIFO: the last one is dropped
        base_tx = n_tx_done;
        for (int i = 1; i <= 17; i++) begin
            push(1'b0, 8'(i));
            if (i == 15) chk_eq("full_at15", bus.o_tx_full, 0);
            if (i == 16) chk_eq("full_at16", bus.o_tx_full, 1);
        end
        chk_eq("full_at17", bus.o_tx_full, 1);
        push(1'b1, 8'h77);
        wait_tx_done("tx_done_wait16", base_tx + 16, 16 * 160 * 3 + 500);
        repeat (20) @(negedge clk);
        chk_eq("tx_done_cnt16", n_tx_done - base_tx, 16);
        chk_eq("tx_empty16", bus.o_tx_empty, 1);
        chk_eq("rx_full16", bus.o_rx_full, 1);
        for (int i = 1; i <= 16; i++) begin
            chk_eq($sformatf("drain%0d", i), bus.o_rdata, 32'(i));
            pop();
        end
        chk_eq("drain_rx_empty", bus.o_rx_empty, 1);

        // Receiver: glitch, framing error, then a clean frame driven by hand
        loop_en = 1'b0;
        base_rx = n_rx_done;
        @(negedge clk);
        rx_man = 1'b0;
        repeat (3 * period) @(negedge clk);
        rx_man = 1'b1;
        repeat (300) @(negedge clk);
        chk_eq("glitch_no_done", n_rx_done - base_rx, 0);
        send_frame(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        chk_eq("frame_err_no_done", n_rx_done - base_rx, 0);
        chk_eq("frame_err_empty", bus.o_rx_empty, 1);
        send_frame(8'h96, 1'b1);
        repeat (20) @(negedge clk);
        chk_eq("manual_done", n_rx_done - base_rx, 1);
        chk_eq("manual_rdata", bus.o_rdata, 8'h96);
        pop();

        // Reset in the middle of a transmitted byte
        loop_en = 1'b1;
        push(1'b0, 8'h11);
        push(1'b1, 8'h81);
        repeat (90) @(negedge clk);
        chk_eq("pre_rst_tx_empty", bus.o_tx_empty, 0);
        base_tx = n_tx_done;
        i_rst = 1'b0;
        #1;
        chk_eq("mid_rst_tx", o_tx, 1);
        chk_eq("mid_rst_tx_empty", bus.o_tx_empty, 1);
        chk_eq("mid_rst_rx_empty", bus.o_rx_empty, 1);
        repeat (5) @(negedge clk);
        i_rst = 1'b1;
        repeat (800) @(negedge clk);
        chk_eq("post_rst_no_done", n_tx_done - base_tx, 0);
        chk_eq("post_rst_tx", o_tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
